scan_display_ctrl: RTL and testbench

Self-timed, parametrised multi-digit display scanner for the board's seven-segment / LED display path. It replaces externally driven scan-select multiplexing with an internal refresh prescaler, and adds:
- Double-buffered (tear-free) data load.
- Per-digit blink.
- Global PWM brightness.

It feeds the segment decoder (4-bit hex nibble plus decimal point) and drives the active-low anode lines directly.

---
 rtl/display_pkg.sv | 23 ++
 rtl/scan_display_ctrl_if.sv | 37 +++
 rtl/scan_prescaler.sv | 24 ++
 rtl/scan_display_ctrl.sv | 169 ++++++++++++++++
 tb/tb_scan_display_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared display constants and helpers for the scan-driven display blocks.
// Provides the nibble width, the anode-off level (anodes are active-low),
// the per-digit output payload and the index-width helper.
package display_pkg;

    localparam int unsigned NIB_W = 4;

    // Level that turns a single anode off; anode buses are all-ones when dark.
    localparam logic ANODE_OFF = 1'b1;

    // Payload shown for the active digit.
    typedef struct packed {
        logic [NIB_W-1:0] hex;
        logic             pt;
        logic             le;
    } digit_out_t;

    // Width of a digit index; never less than 1 bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_display_ctrl_if.sv
// Bus between a display data source and scan_display_ctrl.
// master: drives digit data, load strobe, brightness and blank; sees scan outputs.
// slave : the controller; consumes the data and drives hex_o/p_o/le_o/an_o/scan_o/frame_done.
interface scan_display_ctrl_if #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned BRIGHT_W = 3
);
    import display_pkg::*;

    localparam int unsigned IDX_W = idx_w(DIGITS);

    logic [NIB_W*DIGITS-1:0] hex_in;
    logic [DIGITS-1:0]       point_in;
    logic [DIGITS-1:0]       le_in;
    logic [DIGITS-1:0]       blink_in;
    logic                    load;
    logic [BRIGHT_W-1:0]     brightness;
    logic                    blank;

    logic [NIB_W-1:0]        hex_o;
    logic                    p_o;
    logic                    le_o;
    logic [DIGITS-1:0]       an_o;
    logic [IDX_W-1:0]        scan_o;
    logic                    frame_done;

    modport master (
        output hex_in, point_in, le_in, blink_in, load, brightness, blank,
        input  hex_o, p_o, le_o, an_o, scan_o, frame_done
    );

    modport slave (
        input  hex_in, point_in, le_in, blink_in, load, brightness, blank,
        output hex_o, p_o, le_o, an_o, scan_o, frame_done
    );

endinterface

// File: rtl/scan_prescaler.sv
// Free-running refresh prescaler shared by the display/LED/keypad scanners.
// Ports: clk, rst_n (async active-low), div_cnt (registered counter),
//        tick_c (combinational, high while div_cnt is all-ones).
module scan_prescaler #(
    parameter int unsigned DIV_LOG2 = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [DIV_LOG2-1:0] div_cnt,
    output logic                tick_c
);

    // Wraps naturally; one slot is 2^DIV_LOG2 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_LOG2'(1);
        end
    end

    assign tick_c = &div_cnt;

endmodule

// File: rtl/scan_display_ctrl.sv
// Self-timed multi-digit display scanner with tear-free double-buffered load,
// per-digit blink and global PWM brightness.
// Ports: clk, rst_n (async active-low), bus (scan_display_ctrl_if.slave):
//   inputs  hex_in/point_in/le_in/blink_in/load/brightness/blank
//   outputs hex_o/p_o/le_o (active digit), an_o (active-low anodes),
//           scan_o (active index), frame_done (one-cycle frame pulse).
module scan_display_ctrl
    import display_pkg::*;
#(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned DIV_LOG2   = 16,
    parameter int unsigned BRIGHT_W   = 3,
    parameter int unsigned BLINK_LOG2 = 6
) (
    input logic               clk,
    input logic               rst_n,
    scan_display_ctrl_if.slave bus
);

    localparam int unsigned      IDX_W    = idx_w(DIGITS);
    localparam int unsigned      HEX_W    = NIB_W * DIGITS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ANODE_OFF}};

    logic [DIV_LOG2-1:0]   div_cnt;
    logic                  tick_c;
    logic [DIV_LOG2-1:0]   div_nxt_c;

    logic [IDX_W-1:0]      idx,      idx_nxt_c;
    logic                  pending,  pending_nxt_c;
    logic [HEX_W-1:0]      hex_s,    hex_nxt_c;
    logic [DIGITS-1:0]     pt_s,     pt_nxt_c;
    logic [DIGITS-1:0]     le_s,     le_nxt_c;
    logic [DIGITS-1:0]     blk_s,    blk_nxt_c;
    logic [BLINK_LOG2-1:0] frame_cnt, frame_nxt_c;
    logic                  blink_ph, blink_ph_nxt_c;

    logic                  boundary_c;
    logic                  capture_c;
    logic                  blk_sel_c;
    logic                  on_c;
    logic [DIGITS-1:0]     an_sel_c;
    logic [DIGITS-1:0]     an_nxt_c;
    digit_out_t            out_nxt_c;

    digit_out_t            out_q;
    logic [DIGITS-1:0]     an_q;
    logic [IDX_W-1:0]      scan_q;
    logic                  frame_done_q;

    scan_prescaler #(
        .DIV_LOG2 (DIV_LOG2)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_cnt (div_cnt),
        .tick_c  (tick_c)
    );

    // Next-state logic. Output registers are loaded from the next-state values
    // so that scan_o, frame_done and freshly captured shadows line up on the
    // first cycle of a new frame.
    always_comb begin
        div_nxt_c      = div_cnt + DIV_LOG2'(1);
        boundary_c     = tick_c && (idx == IDX_LAST);
        capture_c      = boundary_c && (pending || bus.load);

        idx_nxt_c      = idx;
        pending_nxt_c  = pending;
        hex_nxt_c      = hex_s;
        pt_nxt_c       = pt_s;
        le_nxt_c       = le_s;
        blk_nxt_c      = blk_s;
        frame_nxt_c    = frame_cnt;
        blink_ph_nxt_c = blink_ph;

        if (tick_c) begin
            idx_nxt_c = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end

        // A load on the boundary cycle itself is captured immediately.
        if (boundary_c) begin
            pending_nxt_c = 1'b0;
        end else if (bus.load) begin
            pending_nxt_c = 1'b1;
        end

        if (capture_c) begin
            hex_nxt_c = bus.hex_in;
            pt_nxt_c  = bus.point_in;
            le_nxt_c  = bus.le_in;
            blk_nxt_c = bus.blink_in;
        end

        if (boundary_c) begin
            frame_nxt_c = frame_cnt + BLINK_LOG2'(1);
            if (&frame_cnt) begin
                blink_ph_nxt_c = ~blink_ph;
            end
        end

        // Select the active digit's payload and anode.
        out_nxt_c = '0;
        blk_sel_c = 1'b0;
        an_sel_c  = AN_OFF;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_nxt_c == IDX_W'(i)) begin
                out_nxt_c.hex = hex_nxt_c[NIB_W*i +: NIB_W];
                out_nxt_c.pt  = pt_nxt_c[i];
                out_nxt_c.le  = le_nxt_c[i];
                blk_sel_c     = blk_nxt_c[i];
                an_sel_c[i]   = ~ANODE_OFF;
            end
        end

        // PWM compares the top BRIGHT_W bits of the slot counter.
        on_c = !bus.blank
            && !(blk_sel_c && blink_ph_nxt_c)
            && (div_nxt_c[DIV_LOG2-1 -: BRIGHT_W] <= bus.brightness);

        an_nxt_c = on_c ? an_sel_c : AN_OFF;
    end

    // Scan, load and blink state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            pending   <= 1'b0;
            hex_s     <= '0;
            pt_s      <= '0;
            le_s      <= '0;
            blk_s     <= '0;
            frame_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            idx       <= idx_nxt_c;
            pending   <= pending_nxt_c;
            hex_s     <= hex_nxt_c;
            pt_s      <= pt_nxt_c;
            le_s      <= le_nxt_c;
            blk_s     <= blk_nxt_c;
            frame_cnt <= frame_nxt_c;
            blink_ph  <= blink_ph_nxt_c;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            an_q         <= AN_OFF;
            scan_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            out_q        <= out_nxt_c;
            an_q         <= an_nxt_c;
            scan_q       <= idx_nxt_c;
            frame_done_q <= boundary_c;
        end
    end

    assign bus.hex_o      = out_q.hex;
    assign bus.p_o        = out_q.pt;
    assign bus.le_o       = out_q.le;
    assign bus.an_o       = an_q;
    assign bus.scan_o     = scan_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl (DIGITS=4, DIV_LOG2=4, BRIGHT_W=2, BLINK_LOG2=1).
// A time-based reference model predicts every output vector per cycle; predictions
// are queued when the stimulus is applied and popped after the clock edge.
module tb_scan_display_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned SLOT   = 16;
    localparam int unsigned FRAME  = 64;

    logic clk;
    logic rst_n;

    scan_display_ctrl_if #(.DIGITS(DIGITS), .BRIGHT_W(2)) bus ();

    scan_display_ctrl #(
        .DIGITS     (DIGITS),
        .DIV_LOG2   (4),
        .BRIGHT_W   (2),
        .BLINK_LOG2 (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int t;
    logic [12:0] sb_q[$];

    logic [15:0] hex_m;
    logic [3:0]  pt_m;
    logic [3:0]  le_m;
    logic [3:0]  blk_m;
    bit          pend_m;

    task automatic model_reset();
        t      = 0;
        hex_m  = '0;
        pt_m   = '0;
        le_m   = '0;
        blk_m  = '0;
        pend_m = 1'b0;
        sb_q.delete();
    endtask

    // Compare outputs against the reset pattern.
    task automatic check_reset(input string tag);
        logic [12:0] got;
        logic [12:0] exp;
        exp = {4'h0, 1'b0, 1'b0, 4'hF, 2'b00, 1'b0};
        got = {bus.hex_o, bus.p_o, bus.le_o, bus.an_o, bus.scan_o, bus.frame_done};
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply current inputs for n cycles, checking each output vector.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            int          tn;
            int          dv;
            int          ix;
            int          ph;
            bit          on;
            logic [3:0]  an_e;
            logic [3:0]  one;
            logic [12:0] exp;
            logic [12:0] got;

            tn = t + 1;
            if (tn % FRAME == 0) begin
                if (pend_m || bus.load) begin
                    hex_m = bus.hex_in;
                    pt_m  = bus.point_in;
                    le_m  = bus.le_in;
                    blk_m = bus.blink_in;
                end
                pend_m = 1'b0;
            end else if (bus.load) begin
                pend_m = 1'b1;
            end

            dv = tn % SLOT;
            ix = (tn / SLOT) % DIGITS;
            ph = (tn / FRAME / 2) % 2;
            on = !bus.blank && !(blk_m[ix] && ph == 1) && ((dv / 4) <= int'(bus.brightness));
            one  = 4'b0001;
            an_e = on ? ~(one << ix) : 4'hF;
            exp  = {hex_m[ix*4 +: 4], pt_m[ix], le_m[ix], an_e, 2'(ix), (tn % FRAME == 0)};
            sb_q.push_back(exp);

            @(posedge clk);
            #1;
            t   = tn;
            got = {bus.hex_o, bus.p_o, bus.le_o, bus.an_o, bus.scan_o, bus.frame_done};
            exp = sb_q.pop_front();
            vectors++;
            assert (got === exp) else begin
                miscompares++;
                $error("FAIL cyc t=%0d got=%h exp=%h (hex,p,le,an,scan,fd)", tn, got, exp);
            end
        end
    endtask

    task automatic step_to(input int phase);
        while (t % FRAME != phase) step(1);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        bus.hex_in     = '0;
        bus.point_in   = '0;
        bus.le_in      = '0;
        bus.blink_in   = '0;
        bus.load       = 1'b0;
        bus.brightness = 2'd3;
        bus.blank      = 1'b0;
        model_reset();

        // Reset and free scan
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        #3 rst_n = 1'b1;
        step(130);

        // Tear-free load requested mid-frame on digit 2
        bus.hex_in   = 16'h1234;
        bus.point_in = 4'b0101;
        bus.le_in    = 4'b1010;
        step_to(40);
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        step(100);

        // Repeated load; data changes before the boundary is what gets captured
        bus.hex_in = 16'h5678;
        step_to(10);
        bus.load = 1'b1;
        step(5);
        bus.load     = 1'b0;
        bus.hex_in   = 16'h9ABC;
        bus.point_in = 4'b1111;
        step(100);

        // Load on the boundary cycle itself
        bus.hex_in = 16'hABCD;
        bus.le_in  = 4'b0110;
        step_to(63);
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        step(70);

        // Brightness and blank
        bus.brightness = 2'd0;
        step(64);
        bus.brightness = 2'd2;
        step(64);
        bus.blank = 1'b1;
        step(64);
        bus.blank      = 1'b0;
        bus.brightness = 2'd3;
        step(10);

        // Blink on digit 1
        bus.blink_in = 4'b0010;
        bus.load     = 1'b1;
        step(1);
        bus.load = 1'b0;
        step(64 * 5);

        // Async reset mid-slot with a load pending
        bus.blink_in = 4'b0000;
        bus.hex_in   = 16'hFEDC;
        step_to(20);
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset("async");
        model_reset();
        #5 rst_n = 1'b1;
        step(140);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
